// File: rtl/ledctrl_pkg.sv
// Shared definitions for the LED controller output stage: default WS2812
// timings for a 25 MHz system clock, frame geometry and the frame FSM states.
package ledctrl_pkg;

    // Default timings in 40 ns clock cycles
    localparam int T0H_CYC       = 10;    // 400 ns high for a '0'
    localparam int T1H_CYC       = 20;    // 800 ns high for a '1'
    localparam int BIT_CYC       = 31;    // 1.24 us bit period
    localparam int LATCH_CYC     = 1500;  // 60 us low latch interval

    // Colour bytes per LED (G, R, B)
    localparam int BYTES_PER_LED = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } tx_state_e;

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single WS2812 bit generator. A load strobe starts a BIT_CYC-long bit
// period; the line is high for T0H_CYC or T1H_CYC cycles depending on the
// bit value, and bit_end_o flags the last cycle of the period so the caller
// can load the next bit with no gap.
module ws2812_bit_tx #(
    parameter int T0H_CYC = 10,
    parameter int T1H_CYC = 20,
    parameter int BIT_CYC = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic bit_i,
    output logic bit_end_o,
    output logic led_o
);

    localparam int CNT_W = $clog2(BIT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             active_q;
    logic             active_d;
    logic             led_q;
    logic             led_d;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [CNT_W-1:0] high_s;

    // Period counter and high-time compare; bit_i is the bit currently on the line
    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        led_d     = led_q;
        cnt_nx_s  = cnt_q + CNT_W'(1);
        high_s    = bit_i ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
        bit_end_o = active_q && (cnt_q == CNT_W'(BIT_CYC - 1));
        if (load_i) begin
            cnt_d    = '0;
            active_d = 1'b1;
            led_d    = (high_s != CNT_W'(0));
        end else if (bit_end_o) begin
            cnt_d    = '0;
            active_d = 1'b0;
            led_d    = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_nx_s;
            led_d = (cnt_nx_s < high_s);
        end else begin
            led_d = 1'b0;
        end
    end

    // Bit-period state; reset forces the line low at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter. On start it reads LED_CNT*3 colour bytes from a
// registered-read memory in address order, sends them MSB-first back to
// back, then holds the line low for the latch interval and pulses done_o.
module ws2812_frame_tx #(
    parameter int   LED_CNT   = 3,
    parameter int   T0H_CYC   = ledctrl_pkg::T0H_CYC,
    parameter int   T1H_CYC   = ledctrl_pkg::T1H_CYC,
    parameter int   BIT_CYC   = ledctrl_pkg::BIT_CYC,
    parameter int   LATCH_CYC = ledctrl_pkg::LATCH_CYC,
    localparam int  ADDR_W    = $clog2(LED_CNT * ledctrl_pkg::BYTES_PER_LED)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic              led_o
);

    import ledctrl_pkg::*;

    localparam int N_BYTES = LED_CNT * BYTES_PER_LED;
    localparam int LAT_W   = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

    if (!((T0H_CYC < T1H_CYC) && (T1H_CYC < BIT_CYC) &&
          (LATCH_CYC >= 1) && (LED_CNT >= 1))) begin : g_param_check
        $error("ws2812_frame_tx: need T0H_CYC < T1H_CYC < BIT_CYC, LATCH_CYC >= 1, LED_CNT >= 1");
    end

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic [7:0]        hold_q;
    logic [7:0]        hold_d;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        bit_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic [LAT_W-1:0]  latch_cnt_q;
    logic [LAT_W-1:0]  latch_cnt_d;
    logic              more_q;
    logic              more_d;
    logic [1:0]        pend_q;
    logic [1:0]        pend_d;
    logic              load_s;
    logic              bit_s;
    logic              bit_end_s;

    // Frame FSM: byte/bit sequencing, prefetch and latch timing
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        latch_cnt_d = latch_cnt_q;
        more_d      = more_q;
        // The memory sees a new address one edge after it changes and
        // presents data one edge later, so capture two edges after prefetch.
        pend_d      = {pend_q[0], 1'b0};
        load_s      = 1'b0;
        bit_s       = shift_q[7];

        if (pend_q[1]) begin
            hold_d = mem_data_i;
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                // Address 0 has been stable since IDLE, so data is valid now
                shift_d   = mem_data_i;
                bit_cnt_d = 3'd7;
                more_d    = 1'b0;
                load_s    = 1'b1;
                bit_s     = mem_data_i[7];
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (bit_end_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        load_s    = 1'b1;
                        bit_s     = shift_q[6];
                        // Entering bit 0: request the next byte if any remain
                        if ((bit_cnt_q == 3'd1) && (addr_q != ADDR_W'(N_BYTES - 1))) begin
                            addr_d    = addr_q + ADDR_W'(1);
                            more_d    = 1'b1;
                            pend_d[0] = 1'b1;
                        end else begin
                            more_d    = more_q;
                        end
                    end else if (more_q) begin
                        shift_d   = hold_q;
                        bit_cnt_d = 3'd7;
                        more_d    = 1'b0;
                        load_s    = 1'b1;
                        bit_s     = hold_q[7];
                    end else begin
                        state_d     = ST_LATCH;
                        latch_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == LAT_W'(LATCH_CYC - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    addr_d  = '0;
                end else begin
                    latch_cnt_d = latch_cnt_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                addr_d  = '0;
            end
        endcase
    end

    // Frame state registers; reset abandons any frame in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            bit_cnt_q   <= 3'd0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            latch_cnt_q <= '0;
            more_q      <= 1'b0;
            pend_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            latch_cnt_q <= latch_cnt_d;
            more_q      <= more_d;
            pend_q      <= pend_d;
        end
    end

    ws2812_bit_tx #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_tx (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_s),
        .bit_i     (bit_s),
        .bit_end_o (bit_end_s),
        .led_o     (led_o)
    );

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_addr_o = addr_q;

endmodule
